// File: rtl/h264_ncoeff_store.sv
// Neighbour TotalCoeff store that predicts nC for CAVLC table selection.
// Define H264_NCOEFF_HD_EN for 1920-pixel lines (120 MB columns); default is 720-pixel lines (45).
module h264_ncoeff_store (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       NEWSLICE,
    input  logic       NEWLINE,
    input  logic       NLOAD,
    input  logic [4:0] NOUT,
    input  logic [2:0] NX,
    input  logic [2:0] NY,
    input  logic [1:0] NV,
    input  logic       NXINC,
    output logic [4:0] NIN,
    output logic       OVF
);

`ifdef H264_NCOEFF_HD_EN
    localparam int MAXMB = 120;
    localparam int MBXW  = 7;
`else
    localparam int MAXMB = 45;
    localparam int MBXW  = 6;
`endif

    logic [4:0]      r_cur  [0:23];
    logic [4:0]      r_left [0:7];
    logic [4:0]      r_top  [0:MAXMB-1][0:7];
    logic [MBXW-1:0] r_mbx;
    logic [4:0]      r_nin;
    logic            r_ovf;

    logic            w_chroma;
    logic            w_cr;
    logic [1:0]      w_x;
    logic [1:0]      w_y;
    logic [4:0]      w_clamp;
    logic [4:0]      w_wrIdx;
    logic [4:0]      w_leftVal;
    logic [4:0]      w_topVal;
    logic [4:0]      w_curWr [0:23];

    // Luma occupies entries 0..15 as y*4+x; Cb 16..19 and Cr 20..23 as 2x2 planes.
    function automatic logic [4:0] curIdx(input logic chroma, input logic cr,
                                          input logic [1:0] x, input logic [1:0] y);
        return chroma ? {2'b10, cr, y[0], x[0]} : {1'b0, y, x};
    endfunction

    assign w_chroma = NX[2] | NY[2];
    assign w_cr     = NX[1];
    assign w_x      = w_chroma ? {1'b0, NX[0]} : NX[1:0];
    assign w_y      = w_chroma ? {1'b0, NY[0]} : NY[1:0];
    assign w_clamp  = (NOUT > 5'd16) ? 5'd16 : NOUT;
    assign w_wrIdx  = curIdx(w_chroma, w_cr, w_x, w_y);

    assign w_leftVal = (w_x != 2'd0)
        ? r_cur[curIdx(w_chroma, w_cr, w_x - 2'd1, w_y)]
        : r_left[w_chroma ? {1'b1, w_cr, w_y[0]} : {1'b0, w_y}];

    assign w_topVal = (w_y != 2'd0)
        ? r_cur[curIdx(w_chroma, w_cr, w_x, w_y - 2'd1)]
        : r_top[r_mbx][w_chroma ? {1'b1, w_cr, w_x[0]} : {1'b0, w_x}];

    // Current MB with this cycle's write applied, so a coincident NXINC copies it too.
    always_comb begin
        for (int i = 0; i < 24; i++) begin
            w_curWr[i] = r_cur[i];
        end
        if (NLOAD) begin
            w_curWr[w_wrIdx] = w_clamp;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET || NEWSLICE) begin
            for (int i = 0; i < 24; i++) r_cur[i] <= '0;
            for (int i = 0; i < 8; i++)  r_left[i] <= '0;
            r_mbx <= '0;
            r_nin <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (NV)
                2'd0:    r_nin <= '0;
                2'd1:    r_nin <= w_leftVal;
                2'd2:    r_nin <= w_topVal;
                default: r_nin <= 5'(({1'b0, w_leftVal} + {1'b0, w_topVal} + 6'd1) >> 1);
            endcase
            if (NXINC) begin
                r_left[0] <= w_curWr[3];
                r_left[1] <= w_curWr[7];
                r_left[2] <= w_curWr[11];
                r_left[3] <= w_curWr[15];
                r_left[4] <= w_curWr[17];
                r_left[5] <= w_curWr[19];
                r_left[6] <= w_curWr[21];
                r_left[7] <= w_curWr[23];
                for (int i = 0; i < 24; i++) r_cur[i] <= '0;
                if (r_mbx == MBXW'(MAXMB - 1)) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_mbx <= r_mbx + 1'b1;
                end
            end else begin
                for (int i = 0; i < 24; i++) r_cur[i] <= w_curWr[i];
            end
            // A new row starts with no left neighbours, even after a coincident NXINC copy.
            if (NEWLINE) begin
                r_mbx <= '0;
                for (int i = 0; i < 8; i++) r_left[i] <= '0;
            end
        end
    end

    // Top line is deliberately not reset; only a slice restart defines it.
    always_ff @(posedge CLK) begin
        if (NEWSLICE) begin
            for (int m = 0; m < MAXMB; m++) begin
                for (int e = 0; e < 8; e++) begin
                    r_top[m][e] <= '0;
                end
            end
        end else if (NXINC && !RESET) begin
            r_top[r_mbx][0] <= w_curWr[12];
            r_top[r_mbx][1] <= w_curWr[13];
            r_top[r_mbx][2] <= w_curWr[14];
            r_top[r_mbx][3] <= w_curWr[15];
            r_top[r_mbx][4] <= w_curWr[18];
            r_top[r_mbx][5] <= w_curWr[19];
            r_top[r_mbx][6] <= w_curWr[22];
            r_top[r_mbx][7] <= w_curWr[23];
        end
    end

    assign NIN = r_nin;
    assign OVF = r_ovf;

endmodule

// File: doc/h264_ncoeff_store.md
H264_NCOEFF_STORE -- requirements
Module: h264_ncoeff_store

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port NEWSLICE, input, 1, synchronous slice restart.
REQ-004 SHALL have port NEWLINE, input, 1, synchronous start of a new macroblock row.
REQ-005 SHALL have port NLOAD, input, 1, write strobe for NOUT.
REQ-006 SHALL have port NOUT, input, 5, TotalCoeff of the block just coded by CAVLC (0..16).
REQ-007 SHALL have port NX, input, 3, block X: bit2=chroma, luma {x1,x0}, chroma {cr,x0}.
REQ-008 SHALL have port NY, input, 3, block Y: bit2=chroma, luma {y1,y0}, chroma {cr,y0}.
REQ-009 SHALL have port NV, input, 2, neighbour validity: 0=none, 1=left, 2=top, 3=both.
REQ-010 SHALL have port NXINC, input, 1, end-of-macroblock pulse.
REQ-011 SHALL have port NIN, output, 5, predicted nC for CAVLC table selection; reset 0.
REQ-012 SHALL have port OVF, output, 1, sticky flag for macroblock column overflow; reset 0.

Function
REQ-013 SHALL hold three stores: current-MB array (16 luma + 4 Cb + 4 Cr entries), left column (4 luma + 2 Cb + 2 Cr), and a top line with 8 entries per MB column indexed by mbx.
REQ-014 On NLOAD, SHALL write min(NOUT,16) to the current-MB entry addressed by the NX/NY of that same cycle.
REQ-015 Left neighbour value SHALL be cur[x-1,y] for x>0, else left[y]; top value SHALL be cur[x,y-1] for y>0, else top[mbx][x].
REQ-016 Chroma addressing SHALL use separate 2x2 Cb and Cr planes selected by NX[1]; chroma never reads luma entries.
REQ-017 NIN SHALL be registered, valid exactly 1 cycle after NX/NY/NV are presented.
REQ-018 NIN SHALL be: NV=0 -> 0; NV=1 -> left; NV=2 -> top; NV=3 -> (left+top+1)>>1, computed in 6 bits.
REQ-019 On NXINC, SHALL copy the current-MB right column (x=3 luma, x=1 chroma) into left.
REQ-020 On NXINC, SHALL copy the current-MB bottom row (y=3 luma, y=1 chroma) into top[mbx].
REQ-021 On NXINC, SHALL increment mbx and clear the current-MB array to 0.
REQ-022 When NLOAD and NXINC coincide, the NLOAD write SHALL be included in the NXINC copies.
REQ-023 NEWLINE SHALL set mbx to 0 and clear left; top-line contents SHALL be retained.
REQ-024 NEWLINE and NXINC in the same cycle: the NXINC copies SHALL complete at the old mbx, and mbx SHALL then become 0.
REQ-025 When mbx equals MAXMB-1, NXINC SHALL hold mbx and set OVF; OVF SHALL clear only on reset or NEWSLICE.
REQ-026 NEWSLICE SHALL override all other inputs: clear all stores, mbx, NIN, and OVF.

Reset
REQ-027 RESET assertion SHALL immediately clear NIN, OVF, mbx, and the left and current arrays, independent of CLK.
REQ-028 Top-line contents SHALL be undefined after RESET until a NEWSLICE occurs; the upstream NV masking is sufficient to cover this.
REQ-029 Deassertion of RESET mid-macroblock SHALL resume from an empty state; no partial write SHALL survive.

Configuration
REQ-030 Macro H264_NCOEFF_HD_EN defined: MAXMB=120 (1920-pixel line) and mbx is 7 bits.
REQ-031 Macro H264_NCOEFF_HD_EN undefined: MAXMB=45 (720-pixel line) and mbx is 6 bits; all other behaviour is identical.

Verification
REQ-032 Scenario: NEWSLICE, NLOAD NX=0 NY=0 NOUT=5, then NX=1 NY=0 NV=1 -> NIN=5 one cycle later.
REQ-033 Scenario: NOUT=20 on NLOAD, then read as left (NV=1) -> NIN=16 (clamp).
REQ-034 Scenario: MB0 bottom row loaded with 3,6,9,12; NXINC; NEWLINE; NX=2 NY=0 NV=2 -> NIN=9.
REQ-035 Scenario: left=7, top=4, NV=3 -> NIN=6; NV=0 -> NIN=0.
REQ-036 Scenario: Cb entry (1,0)=2 and Cr entry (1,0)=11; NXINC; next MB reads Cr x=0 NV=1 -> NIN=11, never 2.
REQ-037 Scenario: issue 46 NXINC pulses without NEWLINE (macro undefined) -> OVF=1 and mbx=44; then NEWSLICE -> OVF=0.
